// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN array read side: geometry, fixed-point
// constants, reader FSM states and the hard-limiter used by the
// CNN_BINARY_OUT_EN build.
package cnn_pkg;

    localparam int CNN_WIDTH = 9;
    localparam int CNN_CELLS = 16;

    // Fixed point {sign, 2^3..2^0, 2^-1..2^-4}
    localparam logic [CNN_WIDTH-1:0] CNN_POS_ONE = 9'b000010000;
    localparam logic [CNN_WIDTH-1:0] CNN_NEG_ONE = 9'b111110000;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        STREAM
    } cnn_rd_state_t;

    // Sign-based hard limit; zero maps to +1.0
    function automatic logic [CNN_WIDTH-1:0] cnn_hard_limit(input logic [CNN_WIDTH-1:0] v);
        return v[CNN_WIDTH-1] ? CNN_NEG_ONE : CNN_POS_ONE;
    endfunction

endpackage

// File: rtl/cnn_settle_detect.sv
// Convergence / timeout detector for the CNN array outputs.
// Tracks the previous Y vector, a run length of unchanged cycles and the
// total cycles spent watching. Pulses converged or timeout combinationally
// in the cycle the parent must take the snapshot; convergence has priority.
module cnn_settle_detect #(
    parameter int DW             = 144,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          active,
    input  logic [DW-1:0] y_flat,
    output logic          converged,
    output logic          timeout
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [DW-1:0] prev_y_q, prev_y_d;
    logic [SW-1:0] stable_cnt_q, stable_cnt_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic          same;

    assign same      = (y_flat == prev_y_q);
    assign converged = active && same && (stable_cnt_q == SW'(SETTLE_CYCLES - 1));
    assign timeout   = active && !converged && (cycle_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counters only move while watching; the parent leaves SETTLE before either can overflow
    always_comb begin
        prev_y_d     = prev_y_q;
        stable_cnt_d = stable_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        if (load) begin
            prev_y_d     = y_flat;
            stable_cnt_d = '0;
            cycle_cnt_d  = '0;
        end else if (active) begin
            prev_y_d     = y_flat;
            cycle_cnt_d  = cycle_cnt_q + CW'(1);
            stable_cnt_d = same ? stable_cnt_q + SW'(1) : '0;
        end
    end

    // Detector state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_y_q     <= '0;
            stable_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            prev_y_q     <= prev_y_d;
            stable_cnt_q <= stable_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

endmodule

// File: rtl/cnn_result_reader.sv
// Read side of the 4x4 CNN array: waits for the Y outputs to settle (or a
// timeout), snapshots them and streams CELLS words over valid/ready.
// All stream outputs are registered, so out_ready never reaches out_valid
// combinationally.
// Build option: CNN_BINARY_OUT_EN hard-limits each cell to +/-1.0 at snapshot.
module cnn_result_reader
    import cnn_pkg::*;
#(
    parameter int WIDTH          = CNN_WIDTH,
    parameter int CELLS          = CNN_CELLS,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CELLS*WIDTH-1:0]   y_flat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(CELLS)-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     timed_out
);

    localparam int DW = CELLS * WIDTH;
    localparam int IW = $clog2(CELLS);

    cnn_rd_state_t state_q, state_d;
    logic [DW-1:0] snap_q, snap_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;
    logic          timed_out_q, timed_out_d;

    logic [DW-1:0] y_proc;
    logic [IW-1:0] idx_inc;
    logic          det_load, det_active, det_conv, det_tmo;

    // Snapshot source: raw Y, or sign-limited Y in the binary build
`ifdef CNN_BINARY_OUT_EN
    for (genvar k = 0; k < CELLS; k++) begin : g_lim
        assign y_proc[k*WIDTH +: WIDTH] =
            WIDTH'(cnn_hard_limit(CNN_WIDTH'(y_flat[k*WIDTH +: WIDTH])));
    end
`else
    assign y_proc = y_flat;
`endif

    assign det_load   = (state_q == IDLE) && start;
    assign det_active = (state_q == SETTLE);
    assign idx_inc    = idx_q + IW'(1);

    cnn_settle_detect #(
        .DW             (DW),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_detect (
        .clk       (clk),
        .rst       (rst),
        .load      (det_load),
        .active    (det_active),
        .y_flat    (y_flat),
        .converged (det_conv),
        .timeout   (det_tmo)
    );

    // Reader FSM: next state plus next values of all registered stream outputs
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        timed_out_d = timed_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETTLE;
                    timed_out_d = 1'b0;
                end
            end
            SETTLE: begin
                if (det_conv || det_tmo) begin
                    state_d     = STREAM;
                    snap_d      = y_proc;
                    idx_d       = '0;
                    out_data_d  = y_proc[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    out_last_d  = (CELLS == 1);
                    timed_out_d = det_tmo;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == IW'(CELLS - 1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = snap_q[int'(idx_inc)*WIDTH +: WIDTH];
                        out_last_d = (idx_inc == IW'(CELLS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign timed_out = timed_out_q;

endmodule
